dct_postfft_twiddle: RTL and testbench



---
 rtl/dct_postfft_twiddle_pkg.sv | 48 ++++
 rtl/dct_postfft_twiddle_if.sv | 42 ++++
 rtl/dct_postfft_twid_rom.sv | 36 +++
 rtl/dct_postfft_twiddle.sv | 209 ++++++++++++++++++++
 tb/tb_dct_postfft_twiddle.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dct_postfft_twiddle_pkg.sv
// Shared constants, error codes, FSM states and stage control bundle
// for the post-FFT DCT twiddle stage.
package dct_postfft_twiddle_pkg;

  localparam int DCT_NMAX      = 2048;
  localparam int DCT_LOG2_NMAX = 11;

  typedef enum logic [1:0] {
    ERR_NONE   = 2'b00,
    ERR_LEN    = 2'b01,
    ERR_ABORT  = 2'b10,
    ERR_ORPHAN = 2'b11
  } err_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_e;

  // tail marks the most recently forwarded sample
  typedef struct packed {
    logic        vld;
    logic        sop;
    logic        eop;
    logic [1:0]  err;
    logic [11:0] n;
    logic        tail;
  } ctl_t;

  // ROM stride for frame size N; anything that is not
  // a power of two in 8..2048 is treated as 2048
  function automatic logic [3:0] twid_shift(
    input logic [11:0] n
  );
    case (n)
      12'd8:    twid_shift = 4'd8;
      12'd16:   twid_shift = 4'd7;
      12'd32:   twid_shift = 4'd6;
      12'd64:   twid_shift = 4'd5;
      12'd128:  twid_shift = 4'd4;
      12'd256:  twid_shift = 4'd3;
      12'd512:  twid_shift = 4'd2;
      12'd1024: twid_shift = 4'd1;
      default:  twid_shift = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/dct_postfft_twiddle_if.sv
// Avalon-ST sink/source bundle of the twiddle stage.
// slave: the block's view; master: the environment's view.
interface dct_postfft_twiddle_if #(
  parameter int wDataInOut = 16
);
  logic                         sink_valid;
  logic                         sink_ready;
  logic [1:0]                   sink_error;
  logic                         sink_sop;
  logic                         sink_eop;
  logic signed [wDataInOut-1:0] sink_real;
  logic signed [wDataInOut-1:0] sink_imag;
  logic [11:0]                  fftpts_in;
  logic                         source_valid;
  logic                         source_ready;
  logic [1:0]                   source_error;
  logic                         source_sop;
  logic                         source_eop;
  logic signed [wDataInOut-1:0] source_real;
  logic signed [wDataInOut-1:0] source_imag;
  logic [11:0]                  fftpts_out;

  modport slave (
    input  sink_valid, sink_error, sink_sop,
    input  sink_eop, sink_real, sink_imag,
    input  fftpts_in, source_ready,
    output sink_ready, source_valid,
    output source_error, source_sop,
    output source_eop, source_real,
    output source_imag, fftpts_out
  );

  modport master (
    output sink_valid, sink_error, sink_sop,
    output sink_eop, sink_real, sink_imag,
    output fftpts_in, source_ready,
    input  sink_ready, source_valid,
    input  source_error, source_sop,
    input  source_eop, source_real,
    input  source_imag, fftpts_out
  );
endinterface

// File: rtl/dct_postfft_twid_rom.sv
// Quarter-wave twiddle ROM: entry i = round(2^(wTwid-2)*{cos,sin}(pi*i/4096)).
// Ports: clk, en_i (read enable / hold), addr_i, cos_o, sin_o (1-cycle sync read).
module dct_postfft_twid_rom
  import dct_postfft_twiddle_pkg::*;
#(
  parameter int wTwid = 16
) (
  input  logic                          clk,
  input  logic                          en_i,
  input  logic [DCT_LOG2_NMAX-1:0]      addr_i,
  output logic signed [wTwid-1:0]       cos_o,
  output logic signed [wTwid-1:0]       sin_o
);

  localparam real PI    = 3.14159265358979323846;
  localparam real SCALE = 2.0 ** (wTwid - 2);

  logic [2*wTwid-1:0] tbl [DCT_NMAX];

  // angles stay below pi/2, so all entries are
  // non-negative and +0.5 truncation rounds
  for (genvar i = 0; i < DCT_NMAX; i++) begin : g_ent
    localparam real A =
      PI * real'(i) / real'(2 * DCT_NMAX);
    localparam int C = $rtoi(SCALE * $cos(A) + 0.5);
    localparam int S = $rtoi(SCALE * $sin(A) + 0.5);
    assign tbl[i] = {C[wTwid-1:0], S[wTwid-1:0]};
  end

  always_ff @(posedge clk) begin
    if (en_i) begin
      {cos_o, sin_o} <= tbl[addr_i];
    end
  end

endmodule

// File: rtl/dct_postfft_twiddle.sv
// Post-FFT DCT twiddle: D1(k) = exp(-j*pi*k/(2N)) * F(k), 4-stage stalling pipe.
// Ports: clk, rst_sync, bus (slave: sink_*, fftpts_in, source_*, fftpts_out).
// Option: DCT_POSTFFT_PKTCHK_EN adds frame length / abort / orphan error codes.
module dct_postfft_twiddle
  import dct_postfft_twiddle_pkg::*;
#(
  parameter int wDataInOut = 16,
  parameter int wTwid      = 16
) (
  input  logic                  clk,
  input  logic                  rst_sync,
  dct_postfft_twiddle_if.slave  bus
);

  localparam int WD = wDataInOut;
  localparam int WP = wDataInOut + wTwid;
  localparam int WS = WP + 1;
  localparam int WR = WS + 1;
  localparam int LN = DCT_LOG2_NMAX;

  localparam logic signed [WR-1:0] RND =
    WR'(1) <<< (wTwid - 3);
  localparam logic signed [WR-1:0] SMAX =
    (WR'(1) <<< (WD - 1)) - WR'(1);
  localparam logic signed [WR-1:0] SMIN =
    -SMAX - WR'(1);

  logic en, acc, sop_acc, fwd, abort;
  logic [1:0] err0;

  state_e        state_q, state_d;
  logic [LN-1:0] k_q, k_d, k_cur;
  logic [11:0]   n_q, n_d, n_cur;

  ctl_t ctl0_d, ctl0_q, ctl1_q, ctl2_q, ctl3_q;

  logic signed [WD-1:0]    fr0_q, fi0_q;
  logic signed [WD-1:0]    fr1_q, fi1_q;
  logic [LN-1:0]           addr0_q;
  logic signed [wTwid-1:0] cos1, sin1;
  logic signed [WP-1:0]    p_rc_q, p_is_q;
  logic signed [WP-1:0]    p_ic_q, p_rs_q;
  logic signed [WS-1:0]    s_re, s_im;
  logic signed [WR-1:0]    r_re, r_im;
  logic signed [WD-1:0]    re_q, im_q;

  // global stall: every stage moves only with en
  assign en  = bus.source_ready | ~bus.source_valid;
  assign bus.sink_ready = en & ~rst_sync;
  assign acc     = bus.sink_valid & bus.sink_ready;
  assign sop_acc = acc & bus.sink_sop;
  assign fwd     = acc &
    (bus.sink_sop | (state_q == ST_FRAME));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    n_d     = n_q;
    k_cur   = k_q;
    n_cur   = n_q;
    if (sop_acc) begin
      k_cur = '0;
      n_cur = bus.fftpts_in;
      n_d   = bus.fftpts_in;
    end
    if (fwd) begin
      k_d     = k_cur + LN'(1);
      state_d = bus.sink_eop ? ST_IDLE : ST_FRAME;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      n_q     <= n_d;
    end
  end

`ifdef DCT_POSTFFT_PKTCHK_EN
  logic [11:0] cnt_q, cnt_d, cnt_cur;
  logic        orph_q, orph_d;

  always_comb begin
    cnt_cur = bus.sink_sop ? 12'd1 : cnt_q + 12'd1;
    cnt_d   = fwd ? cnt_cur : cnt_q;
    orph_d  = orph_q;
    if (acc & ~fwd)
      orph_d = 1'b1;
    else if (fwd & bus.sink_sop)
      orph_d = 1'b0;
    err0 = bus.sink_error;
    if (bus.sink_sop & orph_q)
      err0 = ERR_ORPHAN;
    else if (bus.sink_eop & (cnt_cur != n_cur))
      err0 = ERR_LEN;
  end

  // new sop mid-frame: flag whichever stage holds
  // the last sample of the abandoned frame
  assign abort = sop_acc & (state_q == ST_FRAME);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cnt_q  <= '0;
      orph_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      orph_q <= orph_d;
    end
  end
`else
  assign err0  = bus.sink_error;
  assign abort = 1'b0;
`endif

  function automatic ctl_t adv(
    input ctl_t c,
    input logic ab,
    input logic nf
  );
    adv      = c;
    adv.tail = c.tail & ~nf;
    if (ab & c.tail)
      adv.err = ERR_ABORT;
  endfunction

  function automatic logic signed [WD-1:0] sat(
    input logic signed [WR-1:0] x
  );
    if (x > SMAX)
      sat = SMAX[WD-1:0];
    else if (x < SMIN)
      sat = SMIN[WD-1:0];
    else
      sat = x[WD-1:0];
  endfunction

  always_comb begin
    ctl0_d = '{
      vld:  fwd,
      sop:  bus.sink_sop,
      eop:  bus.sink_eop,
      err:  err0,
      n:    n_cur,
      tail: fwd
    };
  end

  dct_postfft_twid_rom #(
    .wTwid (wTwid)
  ) u_rom (
    .clk    (clk),
    .en_i   (en),
    .addr_i (addr0_q),
    .cos_o  (cos1),
    .sin_o  (sin1)
  );

  always_ff @(posedge clk) begin
    if (en) begin
      fr0_q   <= bus.sink_real;
      fi0_q   <= bus.sink_imag;
      addr0_q <= k_cur << twid_shift(n_cur);
      fr1_q   <= fr0_q;
      fi1_q   <= fi0_q;
      p_rc_q  <= WP'(fr1_q) * WP'(cos1);
      p_is_q  <= WP'(fi1_q) * WP'(sin1);
      p_ic_q  <= WP'(fi1_q) * WP'(cos1);
      p_rs_q  <= WP'(fr1_q) * WP'(sin1);
    end
  end

  assign s_re = WS'(p_rc_q) + WS'(p_is_q);
  assign s_im = WS'(p_ic_q) - WS'(p_rs_q);
  assign r_re = (WR'(s_re) + RND) >>> (wTwid - 2);
  assign r_im = (WR'(s_im) + RND) >>> (wTwid - 2);

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      ctl0_q <= '0;
      ctl1_q <= '0;
      ctl2_q <= '0;
      ctl3_q <= '0;
      re_q   <= '0;
      im_q   <= '0;
    end else if (en) begin
      ctl0_q <= ctl0_d;
      ctl1_q <= adv(ctl0_q, abort, fwd);
      ctl2_q <= adv(ctl1_q, abort, fwd);
      ctl3_q <= adv(ctl2_q, abort, fwd);
      re_q   <= sat(r_re);
      im_q   <= sat(r_im);
    end
  end

  assign bus.source_valid = ctl3_q.vld;
  assign bus.source_sop   = ctl3_q.sop;
  assign bus.source_eop   = ctl3_q.eop;
  assign bus.source_error = ctl3_q.err;
  assign bus.fftpts_out   = ctl3_q.n;
  assign bus.source_real  = re_q;
  assign bus.source_imag  = im_q;

endmodule

// File: tb/tb_dct_postfft_twiddle.sv
// Scoreboard bench for dct_postfft_twiddle:
// random frames against a complex-multiply reference.
module tb_dct_postfft_twiddle;

  logic clk = 1'b0;
  logic rst_sync = 1'b1;
  always #5 clk = ~clk;

  dct_postfft_twiddle_if #(.wDataInOut(16)) bus();

  dct_postfft_twiddle #(
    .wDataInOut (16),
    .wTwid      (16)
  ) dut (
    .clk      (clk),
    .rst_sync (rst_sync),
    .bus      (bus)
  );

  typedef struct {
    int          re;
    int          im;
    logic [1:0]  err;
    logic        sop;
    logic        eop;
    logic [11:0] n;
    int          acc;
    bit          lat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bp_mode = 0;
  bit lat_on = 1'b0;
  bit orphan = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(
    input string nm,
    input logic signed [63:0] act,
    input logic signed [63:0] exp
  );
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // twiddle value for angle pi*i/4096, Q1.14
  function automatic int tw(input int i, input bit s);
    real a, v;
    a = 3.14159265358979323846 * i / 4096.0;
    v = (s ? $sin(a) : $cos(a)) * 16384.0;
    return $rtoi($floor(v + 0.5));
  endfunction

  function automatic int rnd_sat(input longint x);
    longint r;
    r = (x + 64'sd8192) >>> 14;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return int'(r);
  endfunction

  // D1 = exp(-j*pi*k/(2N)) * F
  task automatic model(
    input int fr, input int fi,
    input int k, input int n,
    output int re, output int im
  );
    int idx, c, s;
    idx = (k * (2048 / n)) % 2048;
    c = tw(idx, 1'b0);
    s = tw(idx, 1'b1);
    re = rnd_sat(longint'(fr) * c + longint'(fi) * s);
    im = rnd_sat(longint'(fi) * c - longint'(fr) * s);
  endtask

  task automatic put(
    input bit sop, input bit eop, input int n,
    input int fr, input int fi,
    input logic [1:0] er,
    input bit push, input exp_t e
  );
    int w;
    bit done;
    w = 0;
    done = 1'b0;
    bus.sink_valid = 1'b1;
    bus.sink_sop   = sop;
    bus.sink_eop   = eop;
    bus.fftpts_in  = 12'(n);
    bus.sink_real  = 16'(fr);
    bus.sink_imag  = 16'(fi);
    bus.sink_error = er;
    while (!done) begin
      @(negedge clk);
      if (bus.sink_ready) begin
        done = 1'b1;
        if (push) begin
          e.acc = cyc;
          sb.push_back(e);
        end
      end else begin
        w++;
        if (w > 1000) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout: got 0 expected 1");
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
  endtask

  // mode: 0 const 1000, 1 ramp, 2 random,
  //       3/4 +/- full scale at k=2
  task automatic frame(
    input int n, input int len, input int mode,
    input int gap, input bit do_eop
  );
    for (int k = 0; k < len; k++) begin
      int fr, fi;
      logic [1:0] er;
      exp_t e;
      case (mode)
        0: begin fr = 1000; fi = 0; end
        1: begin fr = k; fi = 0; end
        3: begin
          fr = (k == 2) ? 32767 : 100;
          fi = (k == 2) ? 32767 : -50;
        end
        4: begin
          fr = (k == 2) ? -32768 : 100;
          fi = (k == 2) ? -32768 : -50;
        end
        default: begin
          fr = int'($urandom_range(0, 65535)) - 32768;
          fi = int'($urandom_range(0, 65535)) - 32768;
        end
      endcase
      er = 2'($urandom_range(0, 3));
      model(fr, fi, k, n, e.re, e.im);
      e.sop = (k == 0);
      e.eop = do_eop && (k == len - 1);
      e.n   = 12'(n);
      e.lat = lat_on;
      e.err = er;
`ifdef DCT_POSTFFT_PKTCHK_EN
      if (e.sop && orphan)
        e.err = 2'b11;
      else if (e.eop && len != n)
        e.err = 2'b01;
`endif
      if (e.sop) orphan = 1'b0;
      if (gap > 0)
        repeat ($urandom_range(0, gap)) begin
          @(posedge clk);
          #1;
        end
      put(e.sop, e.eop, n, fr, fi, er, 1'b1, e);
    end
  endtask

  // samples outside a frame must be dropped
  task automatic junk(input int cnt);
    exp_t e;
    e = '{default: 0};
    for (int i = 0; i < cnt; i++)
      put(1'b0, 1'b0, 8, 7, 7, 2'b00, 1'b0, e);
    if (cnt > 0) orphan = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_sync && bus.source_valid &&
        bus.source_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: got %0d expected none",
                 bus.source_real);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("re", bus.source_real, e.re);
        check("im", bus.source_imag, e.im);
        check("err", bus.source_error, e.err);
        check("sop", bus.source_sop, e.sop);
        check("eop", bus.source_eop, e.eop);
        if (e.sop)
          check("fftpts_out", bus.fftpts_out, e.n);
        if (e.lat)
          check("latency", cyc - e.acc, 4);
      end
    end
  end

  initial begin
    bus.source_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (bp_mode == 1)
        bus.source_ready = ($urandom_range(0, 3) != 0);
      else if (bp_mode == 0)
        bus.source_ready = 1'b1;
    end
  end

  task automatic check_idle_outputs(input string nm);
    check({nm, "_valid"}, bus.source_valid, 0);
    check({nm, "_sop"}, bus.source_sop, 0);
    check({nm, "_eop"}, bus.source_eop, 0);
    check({nm, "_error"}, bus.source_error, 0);
    check({nm, "_real"}, bus.source_real, 0);
    check({nm, "_imag"}, bus.source_imag, 0);
    check({nm, "_fftpts"}, bus.fftpts_out, 0);
  endtask

  initial begin
    bus.sink_valid = 1'b0;
    bus.sink_sop   = 1'b0;
    bus.sink_eop   = 1'b0;
    bus.sink_error = 2'b00;
    bus.sink_real  = '0;
    bus.sink_imag  = '0;
    bus.fftpts_in  = 12'd8;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_sink_ready", bus.sink_ready, 0);
    check_idle_outputs("rst");
    @(posedge clk);
    #1;
    rst_sync = 1'b0;
    @(negedge clk);
    check("post_rst_sink_ready", bus.sink_ready, 1);
    @(posedge clk);
    #1;

    // constant input, N=8, latency tagged
    lat_on = 1'b1;
    frame(8, 8, 0, 0, 1'b1);
    // ramp, N=2048
    frame(2048, 2048, 1, 0, 1'b1);
    lat_on = 1'b0;

    // 3-cycle stall mid-frame, N=16
    bp_mode = 2;
    fork
      frame(16, 16, 2, 0, 1'b1);
      begin
        repeat (6) @(posedge clk);
        for (int i = 0; i < 3; i++) begin
          #1;
          bus.source_ready = 1'b0;
          @(negedge clk);
          check("stall_sink_ready", bus.sink_ready, 0);
          @(posedge clk);
        end
        #1;
        bus.source_ready = 1'b1;
        @(negedge clk);
        check("unstall_sink_ready", bus.sink_ready, 1);
      end
    join
    bp_mode = 0;

    // saturation at k=2
    frame(8, 8, 3, 0, 1'b1);
    frame(8, 8, 4, 0, 1'b1);

    // short frame: eop on 12th of 16
    frame(16, 12, 2, 1, 1'b1);
    frame(8, 8, 2, 0, 1'b1);

    // random sizes, gaps, backpressure, orphans
    bp_mode = 1;
    for (int f = 0; f < 12; f++) begin
      int lg;
      lg = int'($urandom_range(3, 6));
      junk(int'($urandom_range(0, 2)));
      frame(1 << lg, 1 << lg, 2, 2, 1'b1);
    end
    bp_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // reset mid-frame drops in-flight data
    frame(16, 5, 2, 0, 1'b0);
    rst_sync = 1'b1;
    @(negedge clk);
    check("midrst_sink_ready", bus.sink_ready, 0);
    @(posedge clk);
    #1;
    sb.delete();
    orphan = 1'b0;
    rst_sync = 1'b0;
    @(negedge clk);
    check_idle_outputs("midrst");
    check("midrst_ready_after", bus.sink_ready, 1);
    @(posedge clk);
    #1;
    lat_on = 1'b1;
    frame(8, 8, 2, 0, 1'b1);
    lat_on = 1'b0;

    for (int i = 0; i < 200 && sb.size() != 0; i++)
      @(posedge clk);
    repeat (8) @(posedge clk);
    check("drain", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
